clock_period_meter: RTL

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_meter_pkg.sv | 22 ++
 rtl/clock_period_meter_sync_edge_detect.sv | 34 +++
 rtl/clock_period_meter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter family.
// The optional high-time measurement in clock_period_meter is enabled
// by defining CLOCK_PERIOD_METER_HIGH_TIME_EN.
package clock_meter_pkg;

    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_TRACK,
        ST_LOCK,
        ST_LOST
    } meter_state_t;

    // States in which a reference rise exists and the timeout is armed
    function automatic logic is_measuring(input meter_state_t s);
        return (s == ST_FIRST) || (s == ST_TRACK) || (s == ST_LOCK);
    endfunction

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Two-flop synchronizer plus history flop for a slow asynchronous input.
// rise/fall are single-cycle strobes decoded from sync stage 2 vs history.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic hist;

    // Synchronizer chain and one-cycle history of the synchronized level
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Edge decode on the synchronized level
    always_comb begin
        rise = sync2 & ~hist;
        fall = ~sync2 & hist;
    end

endmodule

// File: rtl/clock_period_meter.sv
// Measures the rise-to-rise period of a slow clock in clk_in cycles and
// tracks lock/loss. Define CLOCK_PERIOD_METER_HIGH_TIME_EN to also report
// the rise-to-fall interval on high_time; otherwise high_time is tied to 0.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] high_time
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    meter_state_t     state;

    sync_edge_detect u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Saturating successor of cnt: the interval length ending at this cycle
    always_comb begin
        cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
        timeout_hit = is_measuring(state) && !rise && (cnt == TIMEOUT_M1);
    end

    // Registered edge strobes, aligned with the state/period update
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

    // Cycles since the last rise; restarts on rise, saturates at all-ones
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

    // Lock/loss state machine with registered period and status outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_LOST: begin
                    if (rise) begin
                        state  <= ST_FIRST;
                        locked <= 1'b0;
                        lost   <= 1'b0;
                    end
                end
                ST_FIRST, ST_TRACK, ST_LOCK: begin
                    if (rise) begin
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        if (state == ST_FIRST) begin
                            state  <= ST_TRACK;
                            locked <= 1'b0;
                        end else if (cnt_inc == period) begin
                            state  <= ST_LOCK;
                            locked <= 1'b1;
                        end else begin
                            state  <= ST_TRACK;
                            locked <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state  <= ST_LOST;
                        locked <= 1'b0;
                        lost   <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                    lost   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
    // cnt restarts on every rise, so at a fall cnt_inc is the high time
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            high_time <= '0;
        end else if (fall) begin
            high_time <= cnt_inc;
        end
    end
`else
    // High-time measurement disabled: port kept, driven constant
    always_comb begin
        high_time = '0;
    end
`endif

endmodule
